// File: rtl/ram_port_arbiter.sv
// Two-requester front end for a single-port synchronous RAM: round-robin
// arbitration, bounded lock for atomic RMW, and in-order read-return routing.
module ram_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic          lock_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic          lock_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  typedef struct packed {
    logic valid;
    logic owner;    // 0: A, 1: B
    logic is_read;
  } tag_t;

  localparam int            CW       = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LOCK - 1);

  state_t        state, state_nxt, sel_own;
  logic          rr_ptr, rr_ptr_nxt;  // side that wins a tie in IDLE (0: A)
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic          gnt_any, sel_b, sel_lock, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  tag_t          tag1, tag2;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    lock_cnt_nxt = lock_cnt;
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || !rr_ptr)) gnt_a = 1'b1;
        else if (req_b)                   gnt_b = 1'b1;
      end
      OWN_A:   gnt_a = req_a;
      OWN_B:   gnt_b = req_b;
      default: ;
    endcase
    if (!rst_n) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end

    gnt_any   = gnt_a | gnt_b;
    sel_b     = gnt_b;
    sel_lock  = sel_b ? lock_b  : lock_a;
    sel_we    = sel_b ? we_b    : we_a;
    sel_addr  = sel_b ? addr_b  : addr_a;
    sel_wdata = sel_b ? wdata_b : wdata_a;
    sel_own   = sel_b ? OWN_B   : OWN_A;

    if (gnt_any) begin
      rr_ptr_nxt = gnt_a;
      // Hitting the lock limit drops to IDLE where rr_ptr already favours the other side.
      if (!sel_lock || (state == sel_own && lock_cnt == LAST_CNT)) begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end else if (state != sel_own) begin
        state_nxt    = sel_own;
        lock_cnt_nxt = CW'(1);
      end else begin
        lock_cnt_nxt = lock_cnt + CW'(1);
      end
    end else if (state != IDLE) begin
      // Owner skipped a cycle: release ownership.
      state_nxt    = IDLE;
      lock_cnt_nxt = '0;
    end
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag1      <= '0;
      tag2      <= '0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
    end else begin
      mem_en <= gnt_any;
      if (gnt_any) begin
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      // tag1 aligns with mem_* and tag2 with mem_rdata returning from the macro.
      tag1     <= '{valid: gnt_any, owner: sel_b, is_read: !sel_we};
      tag2     <= tag1;
      rvalid_a <= tag2.valid && tag2.is_read && !tag2.owner;
      rvalid_b <= tag2.valid && tag2.is_read &&  tag2.owner;
      if (tag2.valid && tag2.is_read && !tag2.owner) rdata_a <= mem_rdata;
      if (tag2.valid && tag2.is_read &&  tag2.owner) rdata_b <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: behavioural RAM, command queues per
// requester, and a read-return scoreboard checked against a shadow memory.
module tb_ram_port_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_LOCK = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_a = 1'b0, we_a = 1'b0, lock_a = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [DW-1:0] wdata_a = '0;
  logic          req_b = 1'b0, we_b = 1'b0, lock_b = 1'b0;
  logic [AW-1:0] addr_b = '0;
  logic [DW-1:0] wdata_b = '0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  typedef struct {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  cmd_t          cmd_a_q[$];
  cmd_t          cmd_b_q[$];
  int            gnt_log[$];   // per cycle: 0 none, 1 A, 2 B
  exp_t          exp_q[2][$];
  logic [DW-1:0] mem    [2**AW];
  logic [DW-1:0] shadow [2**AW];
  int            checks = 0;
  int            errors = 0;
  int            cycle  = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port synchronous RAM macro, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Watches every cycle: grant rules, memory command, read returns vs scoreboard.
  task automatic monitor();
    logic prev_g = 1'b0;
    cmd_t prev_cmd;
    cmd_t c;
    exp_t e;
    logic rv;
    logic [DW-1:0] rd;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst_n) begin
        exp_q[0].delete();
        exp_q[1].delete();
        prev_g = 1'b0;
      end else begin
        checks++;
        if ((gnt_a && gnt_b) || (gnt_a && !req_a) || (gnt_b && !req_b)) begin
          errors++;
          $display("FAIL grant_rule cycle %0d: gnt_a=%b gnt_b=%b req_a=%b req_b=%b, want exclusive grants only to requesters",
                   cycle, gnt_a, gnt_b, req_a, req_b);
        end
        checks++;
        if (mem_en !== prev_g) begin
          errors++;
          $display("FAIL mem_en cycle %0d: got %b want %b", cycle, mem_en, prev_g);
        end
        if (prev_g) begin
          checks++;
          if (mem_we !== prev_cmd.we || mem_addr !== prev_cmd.addr ||
              (prev_cmd.we && mem_wdata !== prev_cmd.wdata)) begin
            errors++;
            $display("FAIL mem_cmd cycle %0d: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                     cycle, mem_we, mem_addr, mem_wdata, prev_cmd.we, prev_cmd.addr, prev_cmd.wdata);
          end
        end
        for (int s = 0; s < 2; s++) begin
          rv = (s == 0) ? rvalid_a : rvalid_b;
          rd = (s == 0) ? rdata_a  : rdata_b;
          if (rv === 1'b1) begin
            checks++;
            if (exp_q[s].size() == 0) begin
              errors++;
              $display("FAIL rvalid_%s cycle %0d: unexpected return data=%h, want no rvalid", s ? "b" : "a", cycle, rd);
            end else begin
              e = exp_q[s].pop_front();
              if (rd !== e.data || cycle != e.due) begin
                errors++;
                $display("FAIL rdata_%s cycle %0d: got %h want %h due cycle %0d", s ? "b" : "a", cycle, rd, e.data, e.due);
              end
            end
          end
          if (exp_q[s].size() > 0 && exp_q[s][0].due < cycle) begin
            checks++;
            errors++;
            $display("FAIL rvalid_%s missing: expected data %h at cycle %0d, none by cycle %0d",
                     s ? "b" : "a", exp_q[s][0].data, exp_q[s][0].due, cycle);
            void'(exp_q[s].pop_front());
          end
        end
        prev_g = gnt_a | gnt_b;
        if (prev_g) begin
          c.we    = gnt_b ? we_b    : we_a;
          c.lock  = gnt_b ? lock_b  : lock_a;
          c.addr  = gnt_b ? addr_b  : addr_a;
          c.wdata = gnt_b ? wdata_b : wdata_a;
          prev_cmd = c;
          if (c.we) begin
            shadow[c.addr] = c.wdata;
          end else begin
            e.data = shadow[c.addr];
            e.due  = cycle + 3;
            exp_q[gnt_b ? 1 : 0].push_back(e);
          end
        end
      end
    end
  endtask

  task automatic push_cmd(input bit side_b, input bit we, input bit lock,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cmd_t c;
    c.we = we; c.lock = lock; c.addr = addr; c.wdata = wdata;
    if (side_b) cmd_b_q.push_back(c);
    else        cmd_a_q.push_back(c);
  endtask

  // Presents queued commands, holding each until granted; logs who won each cycle.
  task automatic run(input int max_cycles, input bit allow_left);
    int n = 0;
    gnt_log.delete();
    while ((cmd_a_q.size() > 0 || cmd_b_q.size() > 0) && n < max_cycles) begin
      req_a = cmd_a_q.size() > 0;
      if (req_a) begin
        we_a = cmd_a_q[0].we; lock_a = cmd_a_q[0].lock;
        addr_a = cmd_a_q[0].addr; wdata_a = cmd_a_q[0].wdata;
      end
      req_b = cmd_b_q.size() > 0;
      if (req_b) begin
        we_b = cmd_b_q[0].we; lock_b = cmd_b_q[0].lock;
        addr_b = cmd_b_q[0].addr; wdata_b = cmd_b_q[0].wdata;
      end
      @(negedge clk);
      gnt_log.push_back(gnt_a ? 1 : (gnt_b ? 2 : 0));
      if (gnt_a) void'(cmd_a_q.pop_front());
      if (gnt_b) void'(cmd_b_q.pop_front());
      @(posedge clk); #1;
      n++;
    end
    req_a = 1'b0; lock_a = 1'b0;
    req_b = 1'b0; lock_b = 1'b0;
    if (!allow_left) begin
      checks++;
      if (cmd_a_q.size() != 0 || cmd_b_q.size() != 0) begin
        errors++;
        $display("FAIL run_timeout: %0d A and %0d B commands still pending after %0d cycles, want 0",
                 cmd_a_q.size(), cmd_b_q.size(), max_cycles);
      end
    end
    cmd_a_q.delete();
    cmd_b_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(4);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b rdata=%h/%h mem_en=%b mem_we=%b addr=%h wdata=%h, want all 0",
               gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, mem_en, mem_we, mem_addr, mem_wdata);
    end
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_single_port();
    push_cmd(0, 1, 0, 8'h10, 8'h5A);
    push_cmd(0, 0, 0, 8'h10, 8'h00);
    run(10, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (gnt_log[i] !== 1) begin
        errors++;
        $display("FAIL single_gnt[%0d]: got %0d want 1 (A)", i, gnt_log[i]);
      end
    end
    idle(5);
    checks++;
    if (rdata_a !== 8'h5A) begin
      errors++;
      $display("FAIL single_rdata: got %h want 5a", rdata_a);
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 6; i++) begin
      push_cmd(0, 1, 0, AW'(i), DW'(8'h30 + i));
      push_cmd(1, 1, 0, AW'(8'h80 + i), DW'(8'hC0 + i));
    end
    run(30, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push_cmd(0, 0, 0, AW'(i), 8'h00);
      push_cmd(1, 0, 0, AW'(8'h80 + i), 8'h00);
    end
    run(30, 0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (gnt_log[i] !== ((i % 2 == 0) ? 1 : 2)) begin
        errors++;
        $display("FAIL alternate_gnt[%0d]: got %0d want %0d", i, gnt_log[i], (i % 2 == 0) ? 1 : 2);
      end
    end
    idle(5);
    checks++;
    if (rdata_a !== 8'h35 || rdata_b !== 8'hC5) begin
      errors++;
      $display("FAIL interleave_last: got a=%h b=%h want a=35 b=c5", rdata_a, rdata_b);
    end
  endtask

  task automatic test_lock_limit();
    do_reset();
    for (int i = 0; i < 6; i++) push_cmd(0, 0, 1, AW'(i), 8'h00);
    push_cmd(1, 0, 0, 8'h80, 8'h00);
    run(30, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gnt_log[i] !== ((i < MAX_LOCK) ? 1 : 2)) begin
        errors++;
        $display("FAIL lock_gnt[%0d]: got %0d want %0d", i, gnt_log[i], (i < MAX_LOCK) ? 1 : 2);
      end
    end
    idle(5);
  endtask

  task automatic test_rmw();
    push_cmd(0, 1, 0, 8'h20, 8'h07);
    run(10, 0);
    push_cmd(1, 0, 0, 8'h81, 8'h00);   // leaves rr_ptr favouring A
    run(10, 0);
    push_cmd(0, 0, 1, 8'h20, 8'h00);
    push_cmd(0, 1, 0, 8'h20, 8'h08);
    push_cmd(1, 0, 0, 8'h20, 8'h00);
    run(20, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gnt_log[i] !== ((i < 2) ? 1 : 2)) begin
        errors++;
        $display("FAIL rmw_gnt[%0d]: got %0d want %0d", i, gnt_log[i], (i < 2) ? 1 : 2);
      end
    end
    idle(5);
    checks++;
    if (rdata_a !== 8'h07 || rdata_b !== 8'h08) begin
      errors++;
      $display("FAIL rmw_data: got a=%h b=%h want a=07 b=08", rdata_a, rdata_b);
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 4; i++) begin
      push_cmd(0, 0, 0, AW'(i), 8'h00);
      push_cmd(1, 0, 0, AW'(8'h80 + i), 8'h00);
    end
    run(3, 1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL midflight_reset_outputs: gnt=%b%b rvalid=%b%b rdata=%h/%h mem_en=%b, want all 0",
               gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, mem_en);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
        errors++;
        $display("FAIL stale_rvalid[%0d]: got a=%b b=%b want 0 0", i, rvalid_a, rvalid_b);
      end
    end
    @(posedge clk); #1;
    push_cmd(1, 0, 0, 8'h80, 8'h00);
    push_cmd(0, 0, 0, 8'h00, 8'h00);
    run(10, 0);
    checks++;
    if (gnt_log[0] !== 1) begin
      errors++;
      $display("FAIL post_reset_rr: got %0d want 1 (A first)", gnt_log[0]);
    end
    idle(5);
  endtask

  task automatic test_idle();
    idle(3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_en, gnt_a, gnt_b, rvalid_a, rvalid_b} !== 5'b0) begin
        errors++;
        $display("FAIL idle[%0d]: mem_en=%b gnt=%b%b rvalid=%b%b want all 0",
                 i, mem_en, gnt_a, gnt_b, rvalid_a, rvalid_b);
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_port();
    test_interleave();
    test_lock_limit();
    test_rmw();
    test_reset_midflight();
    test_idle();
    checks++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      errors++;
      $display("FAIL leftover_reads: %0d A and %0d B reads never returned, want 0", exp_q[0].size(), exp_q[1].size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
